// File: rtl/simd_ex_pipe.sv
// simd_ex_pipe: multi-stage SIMD execute stage.
//   Lane-wise ADD/SUB/XOR/AND/OR, lane rotate and lane-0 broadcast over LANES x LANE_W vectors.
//   Operands pass through MEM/WB forwarding muxes. The pipeline is STAGES deep, with stall and
//   flush. The destination register and the control sideband travel with each op.
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   in_valid, stall, flush       issue handshake and pipeline control
//   op, alu_src                  operation select, immediate select for operand B
//   data1, data2, imm            register operands and immediate
//   fw1, fw2, fw3                forward sources (MEM mem data, MEM ALU result, WB data)
//   sel_fw_a, sel_fw_b           forward selects (00 reg, 01 fw1, 10 fw2, 11 fw3)
//   rd_in, *_in                  destination register and control sideband
//   out_valid, result            retiring op and its result
//   write_data                   forwarded B before the immediate mux (store data)
//   rd_out, *_out                sideband, forced to 0 while out_valid is low
//   busy                         any stage holds a valid op
//   retired                      saturating count of ops leaving the pipe
module simd_ex_pipe #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 16,
  parameter int unsigned STAGES = 2,
  parameter int unsigned REG_W  = 5,
  localparam int unsigned VW    = LANES * LANE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic             alu_src,
  input  logic [VW-1:0]    data1,
  input  logic [VW-1:0]    data2,
  input  logic [VW-1:0]    imm,
  input  logic [VW-1:0]    fw1,
  input  logic [VW-1:0]    fw2,
  input  logic [VW-1:0]    fw3,
  input  logic [1:0]       sel_fw_a,
  input  logic [1:0]       sel_fw_b,
  input  logic [REG_W-1:0] rd_in,
  input  logic             reg_write_in,
  input  logic             mem_write_in,
  input  logic             mem_to_reg_in,
  output logic             out_valid,
  output logic [VW-1:0]    result,
  output logic [VW-1:0]    write_data,
  output logic [REG_W-1:0] rd_out,
  output logic             reg_write_out,
  output logic             mem_write_out,
  output logic             mem_to_reg_out,
  output logic             busy,
  output logic [15:0]      retired
);

  logic [VW-1:0] op_a, op_bf, op_b, alu_res;

  // Operand selection
  always_comb begin
    unique case (sel_fw_a)
      2'b00:   op_a = data1;
      2'b01:   op_a = fw1;
      2'b10:   op_a = fw2;
      default: op_a = fw3;
    endcase
    unique case (sel_fw_b)
      2'b00:   op_bf = data2;
      2'b01:   op_bf = fw1;
      2'b10:   op_bf = fw2;
      default: op_bf = fw3;
    endcase
    op_b = alu_src ? imm : op_bf;
  end

  // Lane-wise datapath; lanes never carry into each other
  always_comb begin
    alu_res = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      unique case (op)
        3'b000: alu_res[i*LANE_W +: LANE_W] = op_a[i*LANE_W +: LANE_W] + op_b[i*LANE_W +: LANE_W];
        3'b001: alu_res[i*LANE_W +: LANE_W] = op_a[i*LANE_W +: LANE_W] - op_b[i*LANE_W +: LANE_W];
        3'b010: alu_res[i*LANE_W +: LANE_W] = op_a[i*LANE_W +: LANE_W] ^ op_b[i*LANE_W +: LANE_W];
        3'b011: alu_res[i*LANE_W +: LANE_W] = op_a[i*LANE_W +: LANE_W] & op_b[i*LANE_W +: LANE_W];
        3'b100: alu_res[i*LANE_W +: LANE_W] = op_a[i*LANE_W +: LANE_W] | op_b[i*LANE_W +: LANE_W];
        3'b101: alu_res[i*LANE_W +: LANE_W] = op_a[((i + 1) % LANES) * LANE_W +: LANE_W];
        3'b110: alu_res[i*LANE_W +: LANE_W] = op_b[LANE_W-1:0];
        default: alu_res[i*LANE_W +: LANE_W] = op_b[i*LANE_W +: LANE_W];
      endcase
    end
  end

  // Pipeline state; index 0 is stage 1, index STAGES-1 drives the outputs
  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0]            rw_q, rw_d, mw_q, mw_d, mtr_q, mtr_d;
  logic [STAGES-1:0][VW-1:0]    res_q, res_d, wd_q, wd_d;
  logic [STAGES-1:0][REG_W-1:0] rd_q, rd_d;
  logic [15:0]                  retired_q, retired_d;

  always_comb begin
    valid_d   = valid_q;
    rw_d      = rw_q;
    mw_d      = mw_q;
    mtr_d     = mtr_q;
    res_d     = res_q;
    wd_d      = wd_q;
    rd_d      = rd_q;
    retired_d = retired_q;

    // Flush overrides stall: the pipe advances so presented/in-flight ops can be dropped
    if (!stall || flush) begin
      valid_d[0] = in_valid & ~flush;
      rw_d[0]    = reg_write_in;
      mw_d[0]    = mem_write_in;
      mtr_d[0]   = mem_to_reg_in;
      res_d[0]   = alu_res;
      wd_d[0]    = op_bf;
      rd_d[0]    = rd_in;
      for (int unsigned s = 1; s < STAGES; s++) begin
        valid_d[s] = valid_q[s-1];
        rw_d[s]    = rw_q[s-1];
        mw_d[s]    = mw_q[s-1];
        mtr_d[s]   = mtr_q[s-1];
        res_d[s]   = res_q[s-1];
        wd_d[s]    = wd_q[s-1];
        rd_d[s]    = rd_q[s-1];
      end
      if (flush) valid_d = '0;
    end

    if (valid_q[STAGES-1] && !stall && !flush && retired_q != 16'hFFFF) begin
      retired_d = retired_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      rw_q      <= '0;
      mw_q      <= '0;
      mtr_q     <= '0;
      res_q     <= '0;
      wd_q      <= '0;
      rd_q      <= '0;
      retired_q <= '0;
    end else begin
      valid_q   <= valid_d;
      rw_q      <= rw_d;
      mw_q      <= mw_d;
      mtr_q     <= mtr_d;
      res_q     <= res_d;
      wd_q      <= wd_d;
      rd_q      <= rd_d;
      retired_q <= retired_d;
    end
  end

  assign out_valid      = valid_q[STAGES-1];
  assign result         = res_q[STAGES-1];
  assign write_data     = wd_q[STAGES-1];
  assign rd_out         = out_valid ? rd_q[STAGES-1] : '0;
  assign reg_write_out  = out_valid & rw_q[STAGES-1];
  assign mem_write_out  = out_valid & mw_q[STAGES-1];
  assign mem_to_reg_out = out_valid & mtr_q[STAGES-1];
  assign busy           = |valid_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_simd_ex_pipe.sv
module tb_simd_ex_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush, alu_src;
  logic [2:0]  op;
  logic [63:0] data1, data2, imm, fw1, fw2, fw3;
  logic [1:0]  sel_fw_a, sel_fw_b;
  logic [4:0]  rd_in;
  logic        reg_write_in, mem_write_in, mem_to_reg_in;
  logic        out_valid;
  logic [63:0] result, write_data;
  logic [4:0]  rd_out;
  logic        reg_write_out, mem_write_out, mem_to_reg_out, busy;
  logic [15:0] retired;

  int n_vec = 0;
  int n_err = 0;
  int exp_ret = 0;

  simd_ex_pipe #(
    .LANES (4),
    .LANE_W(16),
    .STAGES(2),
    .REG_W (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .stall         (stall),
    .flush         (flush),
    .op            (op),
    .alu_src       (alu_src),
    .data1         (data1),
    .data2         (data2),
    .imm           (imm),
    .fw1           (fw1),
    .fw2           (fw2),
    .fw3           (fw3),
    .sel_fw_a      (sel_fw_a),
    .sel_fw_b      (sel_fw_b),
    .rd_in         (rd_in),
    .reg_write_in  (reg_write_in),
    .mem_write_in  (mem_write_in),
    .mem_to_reg_in (mem_to_reg_in),
    .out_valid     (out_valid),
    .result        (result),
    .write_data    (write_data),
    .rd_out        (rd_out),
    .reg_write_out (reg_write_out),
    .mem_write_out (mem_write_out),
    .mem_to_reg_out(mem_to_reg_out),
    .busy          (busy),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] o, input logic [63:0] d1, input logic [63:0] d2,
                         input logic [63:0] im, input logic src, input logic [1:0] sa,
                         input logic [1:0] sb, input logic [4:0] rd);
    in_valid = 1'b1; op = o; data1 = d1; data2 = d2; imm = im; alu_src = src;
    sel_fw_a = sa; sel_fw_b = sb; rd_in = rd;
    reg_write_in = 1'b1; mem_write_in = 1'b0; mem_to_reg_in = 1'b1;
  endtask

  // Issue one op, check it appears exactly STAGES=2 cycles later for one cycle
  task automatic run_op(input string tag, input logic [2:0] o, input logic [63:0] d1,
                        input logic [63:0] d2, input logic [63:0] im, input logic src,
                        input logic [1:0] sa, input logic [1:0] sb,
                        input logic [63:0] exp_res, input logic [63:0] exp_wd);
    present(o, d1, d2, im, src, sa, sb, 5'd7);
    tick();
    in_valid = 1'b0;
    check_eq({tag, "_early"}, {63'd0, out_valid}, 64'd0);
    tick();
    check_eq({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check_eq({tag, "_result"}, result, exp_res);
    check_eq({tag, "_wdata"}, write_data, exp_wd);
    check_eq({tag, "_rd"}, {59'd0, rd_out}, 64'd7);
    tick();
    exp_ret++;
    check_eq({tag, "_onecyc"}, {63'd0, out_valid}, 64'd0);
    check_eq({tag, "_retired"}, {48'd0, retired}, 64'(exp_ret));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; op = 3'd0; alu_src = 1'b0;
    data1 = '0; data2 = '0; imm = '0; fw1 = '0; fw2 = '0; fw3 = '0;
    sel_fw_a = 2'b00; sel_fw_b = 2'b00; rd_in = '0;
    reg_write_in = 1'b0; mem_write_in = 1'b0; mem_to_reg_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_retired", {48'd0, retired}, 64'd0);
    check_eq("rst_result", result, 64'd0);
    check_eq("rst_rd", {59'd0, rd_out}, 64'd0);

    // ADD, with sideband checks
    present(3'b000, 64'h0001_FFFF_0010_7FFF, 64'h0001_0001_0020_0001, '0, 1'b0, 2'b00, 2'b00,
            5'd3);
    tick();
    in_valid = 1'b0;
    check_eq("add_busy", {63'd0, busy}, 64'd1);
    check_eq("add_early", {63'd0, out_valid}, 64'd0);
    tick();
    check_eq("add_valid", {63'd0, out_valid}, 64'd1);
    check_eq("add_result", result, 64'h0002_0000_0030_8000);
    check_eq("add_rd", {59'd0, rd_out}, 64'd3);
    check_eq("add_ctl", {61'd0, reg_write_out, mem_write_out, mem_to_reg_out}, 64'b101);
    check_eq("add_ret0", {48'd0, retired}, 64'd0);
    tick();
    exp_ret++;
    check_eq("add_onecyc", {63'd0, out_valid}, 64'd0);
    check_eq("add_ctl_gate", {60'd0, rd_out == 5'd0, reg_write_out, mem_write_out,
             mem_to_reg_out}, 64'b1000);
    check_eq("add_retired", {48'd0, retired}, 64'd1);

    run_op("sub_imm", 3'b001, 64'd0, 64'hABCD_0000_0000_1234, 64'h0001_0001_0001_0001, 1'b1,
           2'b00, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hABCD_0000_0000_1234);
    fw2 = 64'h00FF_00FF_00FF_00FF; fw3 = 64'h0F0F_0F0F_0F0F_0F0F;
    run_op("fwd_xor", 3'b010, 64'hDEAD_BEEF_DEAD_BEEF, 64'h1234_5678_9ABC_DEF0, '0, 1'b0,
           2'b10, 2'b11, 64'h0FF0_0FF0_0FF0_0FF0, 64'h0F0F_0F0F_0F0F_0F0F);
    run_op("and", 3'b011, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, '0, 1'b0,
           2'b00, 2'b00, 64'hF000_F000_F000_F000, 64'hFF00_FF00_FF00_FF00);
    run_op("or", 3'b100, 64'hF0F0_0000_1234_0001, 64'h0F0F_0000_4321_0002, '0, 1'b0,
           2'b00, 2'b00, 64'hFFFF_0000_5335_0003, 64'h0F0F_0000_4321_0002);
    run_op("rotl", 3'b101, 64'h4444_3333_2222_1111, 64'd0, '0, 1'b0,
           2'b00, 2'b00, 64'h1111_4444_3333_2222, 64'd0);
    run_op("bcast", 3'b110, 64'd0, 64'h4444_3333_2222_1111, '0, 1'b0,
           2'b00, 2'b00, 64'h1111_1111_1111_1111, 64'h4444_3333_2222_1111);
    fw1 = 64'hCAFE_0001_BABE_0002;
    run_op("pass_fw1", 3'b111, 64'd0, 64'd5, '0, 1'b0,
           2'b00, 2'b01, 64'hCAFE_0001_BABE_0002, 64'hCAFE_0001_BABE_0002);
    run_op("pass_imm", 3'b111, 64'd0, 64'd9, 64'h0123_4567_89AB_CDEF, 1'b1,
           2'b00, 2'b00, 64'h0123_4567_89AB_CDEF, 64'd9);

    // Stall in cycles 1-2 with a held op that must not be captured
    present(3'b000, 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, '0, 1'b0, 2'b00, 2'b00,
            5'd4);
    tick();
    stall = 1'b1;
    present(3'b111, '0, 64'h5555_5555_5555_5555, '0, 1'b0, 2'b00, 2'b00, 5'd9);
    tick();
    check_eq("stall_c2_valid", {63'd0, out_valid}, 64'd0);
    tick();
    check_eq("stall_c3_valid", {63'd0, out_valid}, 64'd0);
    stall = 1'b0; in_valid = 1'b0;
    tick();
    check_eq("stall_c4_valid", {63'd0, out_valid}, 64'd1);
    check_eq("stall_result", result, 64'h0011_0022_0033_0044);
    // Stall while the op sits at the output: it holds and is not counted
    stall = 1'b1;
    tick();
    check_eq("stall_hold_valid", {63'd0, out_valid}, 64'd1);
    check_eq("stall_hold_result", result, 64'h0011_0022_0033_0044);
    check_eq("stall_hold_ret", {48'd0, retired}, 64'(exp_ret));
    stall = 1'b0;
    tick();
    exp_ret++;
    check_eq("stall_drop_held", {62'd0, out_valid, busy}, 64'd0);
    check_eq("stall_retired", {48'd0, retired}, 64'(exp_ret));

    // Flush with stall and in_valid in cycle 2
    present(3'b000, 64'd1, 64'd1, '0, 1'b0, 2'b00, 2'b00, 5'd1);
    tick();
    present(3'b000, 64'd2, 64'd2, '0, 1'b0, 2'b00, 2'b00, 5'd2);
    tick();
    flush = 1'b1; stall = 1'b1;
    present(3'b000, 64'd3, 64'd3, '0, 1'b0, 2'b00, 2'b00, 5'd3);
    check_eq("flush_c2_valid", {63'd0, out_valid}, 64'd1);
    tick();
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    check_eq("flush_c3", {61'd0, out_valid, reg_write_out, busy}, 64'd0);
    check_eq("flush_ret", {48'd0, retired}, 64'(exp_ret));
    tick();
    check_eq("flush_c4", {61'd0, out_valid, reg_write_out, busy}, 64'd0);

    // Reset in cycle 1 discards an op issued in cycle 0
    present(3'b000, 64'd7, 64'd7, '0, 1'b0, 2'b00, 2'b00, 5'd5);
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_mid_state", {61'd0, out_valid, busy, reg_write_out}, 64'd0);
    check_eq("rst_mid_ret", {48'd0, retired}, 64'd0);
    check_eq("rst_mid_result", result, 64'd0);
    tick();
    check_eq("rst_mid_after", {62'd0, out_valid, busy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
